// File: rtl/lift_req_ctrl.sv
// Request front end for lift_sm: synchronises and debounces raw buttons/switches, latches
// them as request LEDs, and issues one held one-hot target at a time until lift_sm clears it.
module lift_req_ctrl #(
    parameter int unsigned DB_TICKS = 3,
    parameter int unsigned DB_W     = 2
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       slowref,
    input  logic       btn_up0,
    input  logic       btn_up1,
    input  logic       btn_dn1,
    input  logic       btn_dn2,
    input  logic       sw0,
    input  logic       sw1,
    input  logic       sw2,
    input  logic [1:0] floorno,
    input  logic       moving,
    input  logic       clrup0,
    input  logic       clrup1,
    input  logic       clrdn1,
    input  logic       clrdn2,
    input  logic       clr_flreq0,
    input  logic       clr_flreq1,
    input  logic       clr_flreq2,
    output logic       upled0,
    output logic       upled1,
    output logic       dnled1,
    output logic       dnled2,
    output logic       flreq_led0,
    output logic       flreq_led1,
    output logic       flreq_led2,
    output logic       pbpulse0,
    output logic       pbpulse1,
    output logic       pbpulse2,
    output logic       sw_pulse0,
    output logic       sw_pulse1,
    output logic       sw_pulse2,
    output logic [1:0] ud,
    output logic       tg0,
    output logic       tg2
);

    typedef enum logic [1:0] {StIdle, StHoldPb, StHoldSw} state_t;

    // Request vector order: {sw2, sw1, sw0, dn2, dn1, up1, up0}
    logic [6:0]      w_raw, w_clr, w_rise, w_drop, w_set;
    logic [6:0]      r_sync1, r_sync2, r_deb, r_deb_q, r_led;
    logic [DB_W-1:0] r_cnt [7];
    logic [2:0]      w_at, w_car, w_hall, w_hall_clr, w_car_pick, w_hall_pick;
    state_t          r_state, w_state_d;
    logic [2:0]      r_pb, r_sw, w_pb_d, w_sw_d;
    logic            r_last_up, w_last_up_d;

    assign w_raw = {sw2, sw1, sw0, btn_dn2, btn_dn1, btn_up1, btn_up0};
    assign w_clr = {clr_flreq2, clr_flreq1, clr_flreq0, clrdn2, clrdn1, clrup1, clrup0};

    // Nearest floor to fl; a floor-1 tie between 0 and 2 follows the last direction.
    function automatic logic [2:0] f_pick(input logic [2:0] req, input logic [1:0] fl,
                                          input logic up);
        logic [2:0] pick;
        pick = 3'b000;
        case (fl)
            2'd1: begin
                if (req[1])                pick = 3'b010;
                else if (req[0] && req[2]) pick = up ? 3'b100 : 3'b001;
                else if (req[2])           pick = 3'b100;
                else if (req[0])           pick = 3'b001;
            end
            2'd2: begin
                if (req[2])      pick = 3'b100;
                else if (req[1]) pick = 3'b010;
                else if (req[0]) pick = 3'b001;
            end
            default: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
        return pick;
    endfunction

    // Direction implied by travelling to a one-hot target; unchanged if already there.
    function automatic logic f_up(input logic [2:0] tgt, input logic [1:0] fl,
                                  input logic cur);
        logic [1:0] tfl;
        tfl = tgt[2] ? 2'd2 : (tgt[1] ? 2'd1 : 2'd0);
        if (tfl > fl)      return 1'b1;
        else if (tfl < fl) return 1'b0;
        else               return cur;
    endfunction

    // Two-flop synchroniser for every raw input.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce paced by slowref: value must differ for DB_TICKS ticks before it is taken.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int i = 0; i < 7; i++) r_cnt[i] <= '0;
        end else begin
            r_deb_q <= r_deb;
            if (slowref) begin
                for (int i = 0; i < 7; i++) begin
                    if (r_sync2[i] != r_deb[i]) begin
                        if (r_cnt[i] == DB_W'(DB_TICKS - 1)) begin
                            r_deb[i] <= r_sync2[i];
                            r_cnt[i] <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + DB_W'(1);
                        end
                    end else begin
                        r_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // A press for the floor the stationary lift is already at is dropped.
    assign w_at   = {floorno == 2'd2, floorno == 2'd1, floorno == 2'd0} & {3{~moving}};
    assign w_drop = {w_at[2], w_at[1], w_at[0], w_at[2], w_at[1], w_at[1], w_at[0]};
    assign w_rise = r_deb & ~r_deb_q;
    assign w_set  = w_rise & ~w_drop;

    // Request LEDs: set on debounced rising edge, clear strobe wins over a same-clk set.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) r_led <= '0;
        else         r_led <= (r_led | w_set) & ~w_clr;
    end

    assign w_car       = r_led[6:4];
    assign w_hall      = {r_led[3], r_led[2] | r_led[1], r_led[0]};
    assign w_hall_clr  = {clrdn2, clrup1 | clrdn1, clrup0};
    assign w_car_pick  = f_pick(w_car, floorno, r_last_up);
    assign w_hall_pick = f_pick(w_hall, floorno, r_last_up);

    // Target FSM state, held target registers and last direction.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state   <= StIdle;
            r_pb      <= '0;
            r_sw      <= '0;
            r_last_up <= 1'b1;
        end else begin
            r_state   <= w_state_d;
            r_pb      <= w_pb_d;
            r_sw      <= w_sw_d;
            r_last_up <= w_last_up_d;
        end
    end

    // Arbitrate on slowref while idle (car first); release on the matching clear every clk.
    always_comb begin
        w_state_d   = r_state;
        w_pb_d      = r_pb;
        w_sw_d      = r_sw;
        w_last_up_d = r_last_up;
        case (r_state)
            StIdle: begin
                if (slowref && !moving) begin
                    if (|w_car) begin
                        w_state_d   = StHoldSw;
                        w_sw_d      = w_car_pick;
                        w_last_up_d = f_up(w_car_pick, floorno, r_last_up);
                    end else if (|w_hall) begin
                        w_state_d   = StHoldPb;
                        w_pb_d      = w_hall_pick;
                        w_last_up_d = f_up(w_hall_pick, floorno, r_last_up);
                    end
                end
            end
            StHoldSw: begin
                if (|(w_clr[6:4] & r_sw)) begin
                    w_state_d = StIdle;
                    w_sw_d    = '0;
                end
            end
            StHoldPb: begin
                if (|(w_hall_clr & r_pb)) begin
                    w_state_d = StIdle;
                    w_pb_d    = '0;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_pb_d    = '0;
                w_sw_d    = '0;
            end
        endcase
    end

    assign {flreq_led2, flreq_led1, flreq_led0, dnled2, dnled1, upled1, upled0} = r_led;
    assign {pbpulse2, pbpulse1, pbpulse0}    = r_pb;
    assign {sw_pulse2, sw_pulse1, sw_pulse0} = r_sw;
    assign ud  = {r_led[1], r_led[2]};
    assign tg0 = r_led[0] | r_led[4];
    assign tg2 = r_led[3] | r_led[6];

endmodule

// File: tb/tb_lift_req_ctrl.sv
// Directed bench for lift_req_ctrl; slowref is driven by hand so every tick is explicit.
module tb_lift_req_ctrl;

    logic       clk = 1'b0;
    logic       resetb, slowref;
    logic       btn_up0, btn_up1, btn_dn1, btn_dn2, sw0, sw1, sw2;
    logic [1:0] floorno;
    logic       moving;
    logic       clrup0, clrup1, clrdn1, clrdn2, clr_flreq0, clr_flreq1, clr_flreq2;
    logic       upled0, upled1, dnled1, dnled2, flreq_led0, flreq_led1, flreq_led2;
    logic       pbpulse0, pbpulse1, pbpulse2, sw_pulse0, sw_pulse1, sw_pulse2;
    logic [1:0] ud;
    logic       tg0, tg2;

    int checks   = 0;
    int failures = 0;

    logic [6:0] leds;
    logic [2:0] pb, swp;
    assign leds = {flreq_led2, flreq_led1, flreq_led0, dnled2, dnled1, upled1, upled0};
    assign pb   = {pbpulse2, pbpulse1, pbpulse0};
    assign swp  = {sw_pulse2, sw_pulse1, sw_pulse0};

    lift_req_ctrl #(.DB_TICKS(3), .DB_W(2)) dut (
        .clk(clk), .resetb(resetb), .slowref(slowref),
        .btn_up0(btn_up0), .btn_up1(btn_up1), .btn_dn1(btn_dn1), .btn_dn2(btn_dn2),
        .sw0(sw0), .sw1(sw1), .sw2(sw2), .floorno(floorno), .moving(moving),
        .clrup0(clrup0), .clrup1(clrup1), .clrdn1(clrdn1), .clrdn2(clrdn2),
        .clr_flreq0(clr_flreq0), .clr_flreq1(clr_flreq1), .clr_flreq2(clr_flreq2),
        .upled0(upled0), .upled1(upled1), .dnled1(dnled1), .dnled2(dnled2),
        .flreq_led0(flreq_led0), .flreq_led1(flreq_led1), .flreq_led2(flreq_led2),
        .pbpulse0(pbpulse0), .pbpulse1(pbpulse1), .pbpulse2(pbpulse2),
        .sw_pulse0(sw_pulse0), .sw_pulse1(sw_pulse1), .sw_pulse2(sw_pulse2),
        .ud(ud), .tg0(tg0), .tg2(tg2)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        slowref = 1'b1;
        cyc();
        slowref = 1'b0;
    endtask

    // Raw press held long enough to reach the LED: 2 sync clks, 3 ticks, 1 latch clk.
    task automatic settle_up();
        cyc();
        cyc();
        repeat (3) tick();
        cyc();
    endtask

    // Let a released input debounce back to 0.
    task automatic settle_dn();
        cyc();
        cyc();
        repeat (3) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        resetb = 1'b0; slowref = 1'b0;
        btn_up0 = 0; btn_up1 = 0; btn_dn1 = 0; btn_dn2 = 0; sw0 = 0; sw1 = 0; sw2 = 0;
        floorno = 2'd0; moving = 1'b0;
        clrup0 = 0; clrup1 = 0; clrdn1 = 0; clrdn2 = 0;
        clr_flreq0 = 0; clr_flreq1 = 0; clr_flreq2 = 0;
        repeat (3) cyc();
        resetb = 1'b1;
        cyc();
        chk("reset_leds", leds, 0);
        chk("reset_pb", pb, 0);
        chk("reset_sw", swp, 0);
        chk("reset_ud", ud, 0);
        chk("reset_tg", {tg2, tg0}, 0);

        // Car request for floor 2 from floor 0
        floorno = 2'd0; sw2 = 1;
        settle_up();
        chk("t2_led", leds, 7'b1000000);
        chk("t2_tg", {tg2, tg0}, 2'b10);
        chk("t2_sw_pre", swp, 0);
        tick();
        chk("t2_sw", swp, 3'b100);
        chk("t2_pb", pb, 0);
        sw2 = 0;
        settle_dn();
        chk("t2_sw_held", swp, 3'b100);
        clr_flreq2 = 1; cyc(); clr_flreq2 = 0;
        chk("t2_led_clr", leds, 0);
        chk("t2_sw_rel", swp, 0);

        // Two-tick glitch on sw1 must not latch
        sw1 = 1;
        cyc(); cyc(); tick(); tick();
        sw1 = 0;
        cyc(); cyc(); repeat (3) tick(); cyc();
        chk("t3_led", leds, 0);
        chk("t3_sw", swp, 0);

        // Press at current floor: dropped when stopped, latched when moving
        floorno = 2'd1; btn_up1 = 1;
        settle_up();
        chk("t5_drop", leds, 0);
        chk("t5_ud_null", ud, 0);
        btn_up1 = 0; settle_dn();
        moving = 1; btn_up1 = 1;
        settle_up();
        chk("t5_led", leds, 7'b0000010);
        chk("t5_ud_up", ud, 2'b10);
        chk("t5_pb_moving", pb, 0);
        btn_up1 = 0; settle_dn();
        clrup1 = 1; cyc(); clrup1 = 0;
        chk("t5_clr", leds, 0);

        // Clear and set of dnled1 in the same clk: clear wins
        btn_dn1 = 1;
        cyc(); cyc(); repeat (3) tick();
        clrdn1 = 1; cyc(); clrdn1 = 0;
        chk("cw_same", leds, 0);
        cyc();
        chk("cw_after", leds, 0);
        btn_dn1 = 0; settle_dn();

        // Hall tie at floor 1: last_dir UP picks floor 2
        moving = 0; floorno = 2'd1;
        btn_up0 = 1; btn_dn2 = 1;
        settle_up();
        chk("t4_led", leds, 7'b0001001);
        chk("t4_tg", {tg2, tg0}, 2'b11);
        tick();
        chk("t4_pb_up", pb, 3'b100);
        btn_up0 = 0; btn_dn2 = 0; settle_dn();
        chk("t4_pb_held", pb, 3'b100);
        clrdn2 = 1; cyc(); clrdn2 = 0;
        chk("t4_pb_rel", pb, 0);
        chk("t4_led_rem", leds, 7'b0000001);
        tick();
        chk("t4_pb_lone", pb, 3'b001);
        clrup0 = 1; cyc(); clrup0 = 0;
        chk("t4_pb_rel2", pb, 0);
        // Same tie, now last_dir DN picks floor 0
        btn_up0 = 1; btn_dn2 = 1;
        settle_up();
        chk("t4_led2", leds, 7'b0001001);
        tick();
        chk("t4_pb_dn", pb, 3'b001);
        btn_up0 = 0; btn_dn2 = 0; settle_dn();
        clrup0 = 1; clrdn2 = 1; cyc(); clrup0 = 0; clrdn2 = 0;
        chk("t4_end_leds", leds, 0);
        chk("t4_end_pb", pb, 0);

        // Car request has priority over hall request at floor 2
        floorno = 2'd2;
        sw1 = 1; btn_up0 = 1;
        settle_up();
        chk("t6_led", leds, 7'b0100001);
        tick();
        chk("t6_sw", swp, 3'b010);
        chk("t6_pb_wait", pb, 0);
        sw1 = 0; btn_up0 = 0; settle_dn();
        chk("t6_pb_wait2", pb, 0);
        clr_flreq1 = 1; cyc(); clr_flreq1 = 0;
        chk("t6_sw_rel", swp, 0);
        tick();
        chk("t6_pb", pb, 3'b001);
        clrup0 = 1; cyc(); clrup0 = 0;
        chk("t6_end_pb", pb, 0);
        chk("t6_end_leds", leds, 0);

        // Reset while holding a car target
        floorno = 2'd0; sw2 = 1;
        settle_up();
        tick();
        chk("t1_hold", swp, 3'b100);
        resetb = 0;
        #1;
        chk("t1_rst_sw", swp, 0);
        chk("t1_rst_leds", leds, 0);
        chk("t1_rst_tg", {tg2, tg0}, 0);
        sw2 = 0;
        cyc(); cyc();
        resetb = 1;
        cyc();
        repeat (4) tick();
        chk("t1_after_sw", swp, 0);
        chk("t1_after_pb", pb, 0);
        chk("t1_after_leds", leds, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
